spi_controller_mode0: RTL
=========================

Name: spi_controller_mode0

Overview:
- SPI controller (master), mode 0 (CPOL=0, CPHA=0), MSB first, single chip select.
- Drives the same pad set that the iCE40 SPI peripheral block receives. Used for on-board bring-up and loopback of that peripheral, and for talking to external SPI devices.
- Parallel byte in/out with a start/busy/DRDY handshake.
- All logic runs in the m_clk domain; SCK is a divided, registered copy of m_clk.

Parameters:
- BYTE_W, 8, bits per transfer; legal range 2 and above.
- CLK_DIV, 2, m_clk cycles per SCK half-period; legal range 1 and above. The divider counter is sized to clog2(CLK_DIV+1).

Ports:
- m_clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a transfer; sampled only in IDLE or in the DRDY cycle.
- d_to_send  input  BYTE_W  byte to transmit; captured when start is accepted.
- busy  output  1  high from start acceptance until the bus is back in IDLE.
- DRDY  output  1  one-cycle pulse; d_recieved is valid from this cycle onward.
- d_recieved  output  BYTE_W  last received byte; holds until the next DRDY.
- sck_pad  output  1  SPI clock; idle low.
- csn_pad  output  1  chip select, active low.
- mosi_pad  output  1  controller data out.
- miso_pad  input  1  peripheral data in.

Behaviour:
- Reset state (asynchronous, takes effect immediately, including mid-transfer): csn_pad=1, sck_pad=0, mosi_pad=0, busy=0, DRDY=0, d_recieved=0, FSM=IDLE, all counters 0.
- FSM states: IDLE, SHIFT, HOLD, GAP. All outputs are registered.
- IDLE:
  - start=1 at edge 0 loads tx_sr=d_to_send and bit counter=0.
  - At edge 1: csn_pad=0, busy=1, mosi_pad=d_to_send[MSB], sck_pad=0. Go to SHIFT.
- SHIFT:
  - SCK low phase and high phase each last CLK_DIV cycles. SCK first rises at edge 1+CLK_DIV.
  - On each falling SCK edge (same m_clk edge that drives sck_pad low): shift miso_pad into rx_sr LSB, shift tx_sr left, and drive the next MSB onto mosi_pad.
  - miso_pad is sampled at the end of the high phase; the peripheral updates MISO only on the SCK falling edge.
  - The peripheral samples MOSI on the SCK rising edge, so mosi_pad is stable for the whole high phase.
  - Falling edge number BYTE_W occurs at edge E = 1 + 2*CLK_DIV*BYTE_W. At E: d_recieved={rx_sr[BYTE_W-2:0], miso_pad}, DRDY=1, sck_pad stays 0.
- DRDY cycle (between E and E+1):
  - If start=1: accept a back-to-back byte. At E+1, load d_to_send, set mosi_pad=MSB; csn_pad stays 0; next SCK rise at E+1+CLK_DIV. The inter-byte low phase is therefore CLK_DIV+1 cycles.
  - Otherwise go to HOLD.
- HOLD: sck_pad=0, csn_pad=0; at edge E+CLK_DIV drive csn_pad=1 and mosi_pad=0, then go to GAP.
- GAP: csn_pad stays high for CLK_DIV cycles; busy=0 at edge E+2*CLK_DIV; then IDLE.
  - A start in the cycle after busy falls is accepted.
- Ignored inputs and stability:
  - start is ignored in SHIFT (other than the DRDY cycle), HOLD and GAP; there is no queueing.
  - d_to_send only needs to be stable in the accepting cycle.
  - DRDY is exactly one cycle and never asserts outside SHIFT completion.
- Reset mid-transfer: csn_pad releases high asynchronously. A partial byte never produces DRDY, and d_recieved is cleared.
- CLK_DIV=1: SCK = m_clk/2; all rules above hold unchanged.

Decomposition:
- Shared package spi_pkg: FSM state encoding (IDLE/SHIFT/HOLD/GAP), the mode-0 CPOL/CPHA constants, and the default BYTE_W.
- One natural sub-module, spi_sck_gen. It holds the half-period counter and registered sck_pad, with enable and restart inputs. It outputs one-cycle rise_tick/fall_tick strobes that are coincident with the sck_pad transitions.

Test Plan:
- Loopback (miso_pad tied to mosi_pad), CLK_DIV=2, d_to_send=0xA5 with a start pulse at cycle 0:
  - csn_pad low at cycle 1, first sck_pad rise at cycle 3, DRDY at cycle 33 with d_recieved=0xA5.
  - csn_pad high at 35, busy low at 37; exactly 8 SCK rising edges.
- Bench SPI mode-0 peripheral model returning 0x3C while the controller sends 0xC3:
  - DRDY with d_recieved=0x3C; the model captures 0xC3.
  - mosi_pad is checked stable across every SCK high phase.
- Back-to-back: start held high, bytes 0x01 then 0xFF:
  - csn_pad stays low throughout; 16 SCK rising edges; two DRDY pulses 33 cycles apart.
  - Second d_recieved=0xFF (loopback).
- Ignored start: start pulses during SHIFT, HOLD and GAP have no effect. Then start=1 on the cycle after busy falls: the transfer begins on the next edge.
- Reset mid-transfer: rst_n low after 3 SCK rising edges:
  - Immediately csn_pad=1, sck_pad=0, busy=0, d_recieved=0; no DRDY.
  - After release, a new 0x5A transfer completes correctly.
- CLK_DIV=1, BYTE_W=16, loopback 0xBEEF: DRDY at cycle 33, d_recieved=0xBEEF, and SCK period is 2 m_clk cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI controller: FSM state encoding,
// clock polarity/phase constants and default sizing.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } spi_state_t;

    // Mode 0: SCK idles low, data launched on the trailing (falling) edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    localparam int unsigned DEFAULT_BYTE_W  = 8;
    localparam int unsigned DEFAULT_CLK_DIV = 2;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period counter plus registered SCK.
// Ports:
//   m_clk, rst_n      clock, async active-low reset
//   i_enable          run the divider; when low SCK is parked at CPOL
//   i_restart         restart a fresh low phase (counter and SCK cleared)
//   o_sck             registered SCK
//   o_rise_tick_c     high in the cycle whose closing edge raises o_sck
//   o_fall_tick_c     high in the cycle whose closing edge lowers o_sck
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic m_clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_sck,
    output logic o_rise_tick_c,
    output logic o_fall_tick_c
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_sck;
    logic             w_toggle;

    // Strobes fire on the same edge that moves r_sck, so the FSM can act in step.
    assign w_toggle      = i_enable && !i_restart && (r_cnt == DIV_W'(CLK_DIV - 1));
    assign o_rise_tick_c = w_toggle && (r_sck == CPOL);
    assign o_fall_tick_c = w_toggle && (r_sck != CPOL);
    assign o_sck         = r_sck;

    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sck <= CPOL;
        end else if (i_restart || !i_enable) begin
            r_cnt <= '0;
            r_sck <= CPOL;
        end else if (w_toggle) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_controller_mode0.sv
// SPI mode-0 controller, MSB first, single chip select, byte handshake.
// Ports:
//   m_clk, rst_n        clock, async active-low reset
//   start, d_to_send    transfer request and byte to send
//   busy                high from acceptance until the bus is idle again
//   DRDY, d_recieved    one-cycle done pulse and last received byte
//   sck_pad, csn_pad, mosi_pad, miso_pad   SPI pads
module spi_controller_mode0
    import spi_pkg::*;
#(
    parameter int unsigned BYTE_W  = DEFAULT_BYTE_W,
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic              m_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] d_to_send,
    output logic              busy,
    output logic              DRDY,
    output logic [BYTE_W-1:0] d_recieved,
    output logic              sck_pad,
    output logic              csn_pad,
    output logic              mosi_pad,
    input  logic              miso_pad
);

    localparam int unsigned BCNT_W = $clog2(BYTE_W + 1);
    localparam int unsigned WCNT_W = $clog2(2 * CLK_DIV + 1);

    spi_state_t          r_state;
    logic                r_load;
    logic [BYTE_W-1:0]   r_tx_sr;
    logic [BYTE_W-2:0]   r_rx_sr;
    logic [BCNT_W-1:0]   r_bit_cnt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_busy;
    logic                r_drdy;
    logic [BYTE_W-1:0]   r_d_rx;
    logic                r_csn;
    logic                r_mosi;

    logic                w_rise_tick_c;
    logic                w_fall_tick_c;
    logic                w_shift_tick_c;
    logic                w_count_tick_c;
    logic                w_sck_en;
    logic                w_sck_restart;
    logic [BYTE_W-1:0]   w_rx_next;

    // Mode 0 counts bits on the leading edge and shifts on the trailing edge.
    assign w_count_tick_c = (CPHA == 1'b0) ? w_rise_tick_c : w_fall_tick_c;
    assign w_shift_tick_c = (CPHA == 1'b0) ? w_fall_tick_c : w_rise_tick_c;

    // SCK runs only while bits are moving; the DRDY cycle parks it low.
    assign w_sck_en      = (r_state == ST_SHIFT) && !r_drdy;
    assign w_sck_restart = ((r_state == ST_IDLE) && r_load) ||
                           ((r_state == ST_SHIFT) && r_drdy && start);
    assign w_rx_next     = {r_rx_sr, miso_pad};

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .m_clk         (m_clk),
        .rst_n         (rst_n),
        .i_enable      (w_sck_en),
        .i_restart     (w_sck_restart),
        .o_sck         (sck_pad),
        .o_rise_tick_c (w_rise_tick_c),
        .o_fall_tick_c (w_fall_tick_c)
    );

    // Transfer sequencing; r_wcnt counts cycles since the final falling edge.
    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_load    <= 1'b0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
            r_wcnt    <= '0;
            r_busy    <= 1'b0;
            r_drdy    <= 1'b0;
            r_d_rx    <= '0;
            r_csn     <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_drdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_load) begin
                        r_load    <= 1'b0;
                        r_state   <= ST_SHIFT;
                        r_csn     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_mosi    <= r_tx_sr[BYTE_W-1];
                        r_bit_cnt <= '0;
                    end else if (start) begin
                        r_tx_sr <= d_to_send;
                        r_load  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_drdy) begin
                        if (start) begin
                            // Back-to-back byte: chip select stays asserted.
                            r_tx_sr   <= d_to_send;
                            r_mosi    <= d_to_send[BYTE_W-1];
                            r_bit_cnt <= '0;
                        end else begin
                            if (r_wcnt == WCNT_W'(CLK_DIV)) begin
                                r_csn   <= 1'b1;
                                r_mosi  <= 1'b0;
                                r_state <= ST_GAP;
                            end else begin
                                r_state <= ST_HOLD;
                            end
                            r_wcnt <= r_wcnt + WCNT_W'(1);
                        end
                    end else begin
                        if (w_count_tick_c) begin
                            r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
                        end
                        if (w_shift_tick_c) begin
                            r_rx_sr <= w_rx_next[BYTE_W-2:0];
                            r_tx_sr <= r_tx_sr << 1;
                            r_mosi  <= r_tx_sr[BYTE_W-2];
                            if (r_bit_cnt == BCNT_W'(BYTE_W)) begin
                                r_d_rx <= w_rx_next;
                                r_drdy <= 1'b1;
                                r_wcnt <= WCNT_W'(1);
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_wcnt == WCNT_W'(CLK_DIV)) begin
                        r_csn   <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= ST_GAP;
                    end
                    r_wcnt <= r_wcnt + WCNT_W'(1);
                end
                ST_GAP: begin
                    if (r_wcnt == WCNT_W'(2 * CLK_DIV)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                        r_wcnt  <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + WCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign DRDY       = r_drdy;
    assign d_recieved = r_d_rx;
    assign csn_pad    = r_csn;
    assign mosi_pad   = r_mosi;

endmodule
